// File: rtl/reg_wb_ctrl.sv
// Register-file write-back queue: merges ALU and load results (loads first) into
// an in-order FIFO and issues one registered register-file write per unstalled cycle.
module reg_wb_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     ALU_Valid,
    output logic                     ALU_Ready,
    input  logic [2:0]               ALU_W_ID,
    input  logic [15:0]              ALU_WData,
    input  logic                     MEM_Valid,
    output logic                     MEM_Ready,
    input  logic [2:0]               MEM_W_ID,
    input  logic [15:0]              MEM_WData,
    input  logic                     WB_Stall,
    output logic [2:0]               Reg_W_ID,
    output logic                     Reg_Write,
    output logic [15:0]              Reg_WData,
    output logic [7:0]               Busy,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [2:0]    id_mem   [DEPTH];
    logic [15:0]   data_mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic [2:0]    reg_w_id_reg;
    logic [15:0]   reg_wdata_reg;
    logic          reg_write_reg;

    logic          full;
    logic          push_mem;
    logic          push_alu;
    logic          push;
    logic          pop;
    logic [2:0]    push_id;
    logic [15:0]   push_data;

    // Full uses the pre-edge count, so a same-cycle pop never frees a slot for a push.
    assign full      = (count_reg == CW'(DEPTH));
    assign MEM_Ready = RST_N & ~full;
    assign ALU_Ready = RST_N & ~full & ~MEM_Valid;

    assign push_mem  = MEM_Valid & MEM_Ready;
    assign push_alu  = ALU_Valid & ALU_Ready;
    assign push      = push_mem | push_alu;
    assign push_id   = push_mem ? MEM_W_ID  : ALU_W_ID;
    assign push_data = push_mem ? MEM_WData : ALU_WData;
    assign pop       = (count_reg != '0) & ~WB_Stall;

    // Queue storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (push) begin
            id_mem[wr_ptr_reg]   <= push_id;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            reg_w_id_reg  <= '0;
            reg_wdata_reg <= '0;
            reg_write_reg <= 1'b0;
        end else begin
            reg_write_reg <= pop;
            if (pop) begin
                reg_w_id_reg  <= id_mem[rd_ptr_reg];
                reg_wdata_reg <= data_mem[rd_ptr_reg];
            end
        end
    end

    // Per-slot scoreboard contribution: a slot counts only if it lies inside the live window.
    logic [7:0] entry_busy [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [AW-1:0] offset;
            assign offset         = AW'(gi) - rd_ptr_reg;
            assign entry_busy[gi] = ({1'b0, offset} < count_reg) ? (8'b1 << id_mem[gi]) : 8'h00;
        end
    endgenerate

    logic [7:0] busy_next;

    always_comb begin
        busy_next = 8'h00;
        for (int i = 0; i < DEPTH; i++)
            busy_next = busy_next | entry_busy[i];
    end

    assign Busy      = busy_next;
    assign Count     = count_reg;
    assign Reg_W_ID  = reg_w_id_reg;
    assign Reg_WData = reg_wdata_reg;
    assign Reg_Write = reg_write_reg;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed bench for reg_wb_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_reg_wb_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        ALU_Valid;
    logic        ALU_Ready;
    logic [2:0]  ALU_W_ID;
    logic [15:0] ALU_WData;
    logic        MEM_Valid;
    logic        MEM_Ready;
    logic [2:0]  MEM_W_ID;
    logic [15:0] MEM_WData;
    logic        WB_Stall;
    logic [2:0]  Reg_W_ID;
    logic        Reg_Write;
    logic [15:0] Reg_WData;
    logic [7:0]  Busy;
    logic [2:0]  Count;

    int checks;
    int errors;

    reg_wb_ctrl #(.DEPTH(4)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ALU_Valid (ALU_Valid),
        .ALU_Ready (ALU_Ready),
        .ALU_W_ID  (ALU_W_ID),
        .ALU_WData (ALU_WData),
        .MEM_Valid (MEM_Valid),
        .MEM_Ready (MEM_Ready),
        .MEM_W_ID  (MEM_W_ID),
        .MEM_WData (MEM_WData),
        .WB_Stall  (WB_Stall),
        .Reg_W_ID  (Reg_W_ID),
        .Reg_Write (Reg_Write),
        .Reg_WData (Reg_WData),
        .Busy      (Busy),
        .Count     (Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic check_wr(input string tag, input logic [2:0] id, input logic [15:0] data);
        check({tag, "_we"},   32'(Reg_Write), 32'd1);
        check({tag, "_id"},   32'(Reg_W_ID),  32'(id));
        check({tag, "_data"}, 32'(Reg_WData), 32'(data));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        RST_N     = 1'b0;
        ALU_Valid = 1'b0;
        ALU_W_ID  = 3'd0;
        ALU_WData = 16'h0;
        MEM_Valid = 1'b0;
        MEM_W_ID  = 3'd0;
        MEM_WData = 16'h0;
        WB_Stall  = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_count", 32'(Count), 32'd0);
        check("rst_busy",  32'(Busy), 32'h0);
        check("rst_we",    32'(Reg_Write), 32'd0);
        check("rst_id",    32'(Reg_W_ID), 32'd0);
        check("rst_data",  32'(Reg_WData), 32'h0);
        check("rst_mrdy",  32'(MEM_Ready), 32'd0);
        check("rst_ardy",  32'(ALU_Ready), 32'd0);
        RST_N = 1'b1;

        // Single load write
        MEM_Valid = 1'b1; MEM_W_ID = 3'd3; MEM_WData = 16'h1234;
        #1 check("single_mrdy", 32'(MEM_Ready), 32'd1);
        @(negedge CLK);
        MEM_Valid = 1'b0;
        check("single_cnt1", 32'(Count), 32'd1);
        check("single_busy", 32'(Busy), 32'h08);
        check("single_we0",  32'(Reg_Write), 32'd0);
        @(negedge CLK);
        check_wr("single_wr", 3'd3, 16'h1234);
        check("single_cnt0",  32'(Count), 32'd0);
        check("single_busy0", 32'(Busy), 32'h00);
        @(negedge CLK);
        check("single_we_off", 32'(Reg_Write), 32'd0);
        check("single_hold",   32'(Reg_WData), 32'h1234);

        // MEM priority over ALU
        ALU_Valid = 1'b1; ALU_W_ID = 3'd1; ALU_WData = 16'hAAAA;
        MEM_Valid = 1'b1; MEM_W_ID = 3'd2; MEM_WData = 16'h5555;
        #1;
        check("prio_ardy", 32'(ALU_Ready), 32'd0);
        check("prio_mrdy", 32'(MEM_Ready), 32'd1);
        @(negedge CLK);
        MEM_Valid = 1'b0;
        check("prio_cnt",  32'(Count), 32'd1);
        check("prio_busy", 32'(Busy), 32'h04);
        #1 check("prio_ardy2", 32'(ALU_Ready), 32'd1);
        @(negedge CLK);
        ALU_Valid = 1'b0;
        check_wr("prio_wr_r2", 3'd2, 16'h5555);
        check("prio_cnt_pp", 32'(Count), 32'd1);
        check("prio_busy2",  32'(Busy), 32'h02);
        @(negedge CLK);
        check_wr("prio_wr_r1", 3'd1, 16'hAAAA);
        check("prio_cnt0", 32'(Count), 32'd0);

        // Fill under stall, then drain while a push is refused at full
        WB_Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            MEM_Valid = 1'b1; MEM_W_ID = 3'(i); MEM_WData = 16'(i);
            @(negedge CLK);
        end
        MEM_Valid = 1'b0;
        #1;
        check("full_cnt",  32'(Count), 32'd4);
        check("full_busy", 32'(Busy), 32'h0F);
        check("full_mrdy", 32'(MEM_Ready), 32'd0);
        check("full_ardy", 32'(ALU_Ready), 32'd0);
        check("full_we",   32'(Reg_Write), 32'd0);
        WB_Stall = 1'b0;
        MEM_Valid = 1'b1; MEM_W_ID = 3'd7; MEM_WData = 16'hBEEF;
        @(negedge CLK);
        MEM_Valid = 1'b0;
        check_wr("drain_r0", 3'd0, 16'd0);
        check("drain_cnt3", 32'(Count), 32'd3);
        for (int i = 1; i < 4; i++) begin
            @(negedge CLK);
            check_wr($sformatf("drain_r%0d", i), 3'(i), 16'(i));
        end
        @(negedge CLK);
        check("drain_we0",  32'(Reg_Write), 32'd0);
        check("drain_cnt0", 32'(Count), 32'd0);
        check("drain_busy", 32'(Busy), 32'h00);

        // Two writes to the same register stay ordered
        WB_Stall = 1'b1;
        MEM_Valid = 1'b1; MEM_W_ID = 3'd5; MEM_WData = 16'h0001;
        @(negedge CLK);
        MEM_WData = 16'h0002;
        @(negedge CLK);
        MEM_Valid = 1'b0;
        check("same_cnt",  32'(Count), 32'd2);
        check("same_busy", 32'(Busy), 32'h20);
        WB_Stall = 1'b0;
        @(negedge CLK);
        check_wr("same_first", 3'd5, 16'h0001);
        check("same_busy1", 32'(Busy), 32'h20);
        @(negedge CLK);
        check_wr("same_second", 3'd5, 16'h0002);
        check("same_busy0", 32'(Busy), 32'h00);

        // Reset in the middle of a stalled queue
        WB_Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ALU_Valid = 1'b1; ALU_W_ID = 3'd6; ALU_WData = 16'h0010 + 16'(i);
            @(negedge CLK);
        end
        ALU_Valid = 1'b0;
        check("mid_cnt",  32'(Count), 32'd3);
        check("mid_busy", 32'(Busy), 32'h40);
        #1;
        RST_N = 1'b0; MEM_Valid = 1'b1; ALU_Valid = 1'b1;
        #1;
        check("mid_rst_cnt",  32'(Count), 32'd0);
        check("mid_rst_busy", 32'(Busy), 32'h00);
        check("mid_rst_we",   32'(Reg_Write), 32'd0);
        check("mid_rst_mrdy", 32'(MEM_Ready), 32'd0);
        check("mid_rst_ardy", 32'(ALU_Ready), 32'd0);
        #1;
        MEM_Valid = 1'b0; ALU_Valid = 1'b0; WB_Stall = 1'b0; RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("post_rst_we%0d", i), 32'(Reg_Write), 32'd0);
        end

        // First acceptance right after a reset release
        @(negedge CLK);
        RST_N = 1'b0;
        #1 RST_N = 1'b1;
        MEM_Valid = 1'b1; MEM_W_ID = 3'd4; MEM_WData = 16'hC0DE;
        @(negedge CLK);
        MEM_Valid = 1'b0;
        check("rel_cnt",  32'(Count), 32'd1);
        check("rel_busy", 32'(Busy), 32'h10);
        @(negedge CLK);
        check_wr("rel_wr", 3'd4, 16'hC0DE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_wb_ctrl.md
REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, write-back queue entries; legal values are powers of 2 from 2 to 16.
REQ-002 SHALL have ports, in this order:
  CLK  in  1  clock; all state updates on rising edge.
  RST_N  in  1  asynchronous reset, active-low.
  ALU_Valid  in  1  ALU result offered.
  ALU_Ready  out  1  ALU result accepted this cycle when high with ALU_Valid.
  ALU_W_ID  in  3  ALU destination register.
  ALU_WData  in  16  ALU result.
  MEM_Valid  in  1  load result offered.
  MEM_Ready  out  1  load result accepted this cycle when high with MEM_Valid.
  MEM_W_ID  in  3  load destination register.
  MEM_WData  in  16  load data.
  WB_Stall  in  1  blocks issue of register-file writes.
  Reg_W_ID  out  3  register-file write index.
  Reg_Write  out  1  register-file write enable; one cycle per write.
  Reg_WData  out  16  register-file write data.
  Busy  out  8  bit i high while a queued entry targets register i.
  Count  out  clog2(DEPTH)+1  queued entries, 0..DEPTH.

Function
REQ-003 SHALL buffer results in an in-order FIFO of DEPTH entries; each entry holds {W_ID[2:0], WData[15:0]}.
REQ-004 SHALL accept at most one push per cycle.
REQ-005 SHALL give MEM priority: MEM_Ready = RST_N & ~full.
REQ-006 SHALL compute ALU_Ready = RST_N & ~full & ~MEM_Valid; an ALU offer SHALL be held by the source until accepted.
REQ-007 SHALL define full as Count==DEPTH, using the pre-edge count; a pop in the same cycle SHALL NOT make room for a push.
REQ-008 SHALL pop the head entry on a rising edge when Count>0 and WB_Stall==0.
REQ-009 SHALL register the popped entry onto Reg_W_ID and Reg_WData with Reg_Write=1 for exactly that cycle, so the register file samples stable values on the following falling edge.
REQ-010 SHALL drive Reg_Write=0 in any cycle without a pop, and Reg_W_ID and Reg_WData SHALL hold their last values.
REQ-011 SHALL have a minimum latency of 2 rising edges from acceptance to the Reg_Write pulse: push at edge k, earliest pop at edge k+1.
REQ-012 SHALL update Count for a simultaneous push and pop as Count+1-1: unchanged, with both the push and the pop taking effect.
REQ-013 SHALL wrap read and write pointers modulo DEPTH; the FIFO SHALL NOT underflow when Count==0 and SHALL NOT overflow when Count==DEPTH.
REQ-014 SHALL compute Busy combinationally from the valid FIFO entries only; the entry currently on Reg_* outputs is excluded.
REQ-015 SHALL keep Busy[i] high while any queued entry targets register i, including multiple entries to the same register.
REQ-016 SHALL preserve writes to the same register in acceptance order, so the last accepted value is written last.
REQ-017 SHALL treat all 8 register IDs identically; there is no hardwired zero register.
REQ-018 SHALL keep WB_Stall from affecting acceptance other than through full.

Reset
REQ-019 SHALL, while RST_N==0 (asynchronously), clear the pointers, Count=0, Reg_Write=0, Reg_W_ID=0, Reg_WData=0 and Busy=0, and drive ALU_Ready=0 and MEM_Ready=0.
REQ-020 SHALL discard all queued entries on reset mid-operation, with no partial write pulse.
REQ-021 SHALL allow the first acceptance on the first rising edge after RST_N deasserts.

Verification
REQ-022 Single write: MEM_Valid=1, MEM_W_ID=3, MEM_WData=16'h1234 for 1 cycle, WB_Stall=0 -> next cycle Reg_Write=1, Reg_W_ID=3, Reg_WData=16'h1234 for one cycle; Busy[3] high for exactly one cycle; Count 0->1->0.
REQ-023 Priority: ALU_Valid=1 (R1, 16'hAAAA) and MEM_Valid=1 (R2, 16'h5555) together -> ALU_Ready=0, MEM accepted first; register-file writes occur in order R2 then R1.
REQ-024 Full/stall: WB_Stall=1, push 4 entries R0..R3 with data 0..3 -> Count=4, Busy=8'h0F, both readies 0; release WB_Stall -> 4 consecutive Reg_Write pulses R0..R3 with data 0..3; push and pop at Count=4 -> no push.
REQ-025 Same-register ordering: push R5=16'h0001 then R5=16'h0002 under stall -> Busy[5] stays high until the second is popped; writes 0001 then 0002.
REQ-026 Reset mid-operation: Count=3 with WB_Stall=1, pulse RST_N low between edges -> immediately Count=0, Busy=0, Reg_Write=0, readies 0; no Reg_Write pulse after release.
